// File: rtl/writeback_controller_if.sv
`default_nettype none
//==============================================================================
// Module   : writeback_controller_if
// Brief    : Eviction, dirty-bit, data-array and memory-write signals of the
//            write-back cache eviction path.
// Revision : 1.0 - initial release
//==============================================================================
interface writeback_controller_if #(
    parameter int NUM_SETS   = 1,
    parameter int ASSOC      = 1,
    parameter int LINE_WORDS = 4,
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int SET_SIZE   = $clog2(NUM_SETS);
    localparam int ASSOC_SIZE = $clog2(ASSOC);
    localparam int WORD_SIZE  = $clog2(LINE_WORDS);
    localparam int TAG_SIZE   = ADDR_WIDTH - SET_SIZE - WORD_SIZE - $clog2(XLEN / 8);
    // A single set, way or word still gets a one-bit field so the ports stay legal
    localparam int SET_W      = (SET_SIZE > 0) ? SET_SIZE : 1;
    localparam int WAY_W      = (ASSOC_SIZE > 0) ? ASSOC_SIZE : 1;
    localparam int WORD_W     = (WORD_SIZE > 0) ? WORD_SIZE : 1;

    logic                  evict_valid;
    logic                  evict_ready;
    logic [SET_W-1:0]      evict_set;
    logic [WAY_W-1:0]      evict_way;
    logic [TAG_SIZE-1:0]   evict_tag;
    logic                  evict_done;
    logic                  evict_wrote_back;
    logic [SET_W-1:0]      victim_set;
    logic [WAY_W-1:0]      victim_way;
    logic                  selected_dirty_bit;
    logic                  clear_selected_dirty_bit;
    logic                  data_rd_en;
    logic [WORD_W-1:0]     data_word;
    logic [XLEN-1:0]       data_rdata;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [XLEN-1:0]       mem_wdata;
    logic                  mem_ack;
    logic [15:0]           wb_count;

    // slave: the writeback controller; master: miss FSM, dirty bits, data array, memory
    modport slave (
        input  evict_valid, evict_set, evict_way, evict_tag,
        input  selected_dirty_bit, data_rdata, mem_ack,
        output evict_ready, evict_done, evict_wrote_back, victim_set, victim_way,
        output clear_selected_dirty_bit, data_rd_en, data_word,
        output mem_req, mem_addr, mem_wdata, wb_count
    );

    modport master (
        output evict_valid, evict_set, evict_way, evict_tag,
        output selected_dirty_bit, data_rdata, mem_ack,
        input  evict_ready, evict_done, evict_wrote_back, victim_set, victim_way,
        input  clear_selected_dirty_bit, data_rd_en, data_word,
        input  mem_req, mem_addr, mem_wdata, wb_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_controller.sv
`default_nettype none
//==============================================================================
// Module   : writeback_controller
// Brief    : Evicts a victim line; a dirty line is streamed word by word to
//            memory and its dirty bit cleared. `define WB_STATS_EN enables the
//            saturating writeback counter on wb_count.
// Revision : 1.0 - initial release
//==============================================================================
module writeback_controller #(
    parameter int NUM_SETS   = 1,
    parameter int ASSOC      = 1,
    parameter int LINE_WORDS = 4,
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    writeback_controller_if.slave bus
);
    localparam int SET_SIZE   = $clog2(NUM_SETS);
    localparam int ASSOC_SIZE = $clog2(ASSOC);
    localparam int WORD_SIZE  = $clog2(LINE_WORDS);
    localparam int BYTE_OFF   = $clog2(XLEN / 8);
    localparam int TAG_SIZE   = ADDR_WIDTH - SET_SIZE - WORD_SIZE - BYTE_OFF;
    localparam int SET_W      = (SET_SIZE > 0) ? SET_SIZE : 1;
    localparam int WAY_W      = (ASSOC_SIZE > 0) ? ASSOC_SIZE : 1;
    localparam int WORD_W     = (WORD_SIZE > 0) ? WORD_SIZE : 1;

    localparam logic [WORD_W-1:0] c_LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [WORD_W-1:0] c_WORD_ONE  = WORD_W'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CHECK = 3'd1;
    localparam logic [2:0] c_ST_READ  = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_CLEAR = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [SET_W-1:0]      r_set;
    logic [WAY_W-1:0]      r_way;
    logic [TAG_SIZE-1:0]   r_tag;
    logic [WORD_W-1:0]     r_word;
    logic [XLEN-1:0]       r_wdata;
    logic                  r_wrote_back;
    logic                  w_evict_ready;
    logic                  w_evict_done;
    logic                  w_data_rd_en;
    logic                  w_mem_req;
    logic                  w_clear;
    logic [ADDR_WIDTH-1:0] w_tag_part;
    logic [ADDR_WIDTH-1:0] w_set_part;
    logic [ADDR_WIDTH-1:0] w_word_part;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Strobes depend on r_state only; inputs steer the next state alone
    always_comb begin
        w_next_state  = r_state;
        w_evict_ready = 1'b0;
        w_evict_done  = 1'b0;
        w_data_rd_en  = 1'b0;
        w_mem_req     = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_evict_ready = 1'b1;
                if (bus.evict_valid) begin
                    w_next_state = c_ST_CHECK;
                end
            end
            c_ST_CHECK: begin
                w_next_state = bus.selected_dirty_bit ? c_ST_READ : c_ST_DONE;
            end
            c_ST_READ: begin
                w_data_rd_en = 1'b1;
                w_next_state = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_next_state = (r_word == c_LAST_WORD) ? c_ST_CLEAR : c_ST_READ;
                end
            end
            c_ST_CLEAR: begin
                w_clear      = 1'b1;
                w_next_state = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_evict_done = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set        <= '0;
            r_way        <= '0;
            r_tag        <= '0;
            r_word       <= '0;
            r_wdata      <= '0;
            r_wrote_back <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.evict_valid) begin
                        r_set  <= bus.evict_set;
                        r_way  <= bus.evict_way;
                        r_tag  <= bus.evict_tag;
                        r_word <= '0;
                    end
                end
                c_ST_READ: begin
                    r_wdata <= bus.data_rdata;
                end
                c_ST_WRITE: begin
                    if (bus.mem_ack && (r_word != c_LAST_WORD)) begin
                        r_word <= r_word + c_WORD_ONE;
                    end
                end
                c_ST_CLEAR: begin
                    r_wrote_back <= 1'b1;
                end
                c_ST_DONE: begin
                    r_wrote_back <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory address is {tag, set, word, byte=0}; absent fields contribute nothing
    assign w_tag_part = ADDR_WIDTH'(r_tag) << (ADDR_WIDTH - TAG_SIZE);

    generate
        if (SET_SIZE > 0) begin : g_set_field
            assign w_set_part = ADDR_WIDTH'(r_set) << (WORD_SIZE + BYTE_OFF);
        end else begin : g_no_set_field
            assign w_set_part = '0;
        end
        if (WORD_SIZE > 0) begin : g_word_field
            assign w_word_part = ADDR_WIDTH'(r_word) << BYTE_OFF;
        end else begin : g_no_word_field
            assign w_word_part = '0;
        end
    endgenerate

    assign bus.evict_ready              = w_evict_ready;
    assign bus.evict_done               = w_evict_done;
    assign bus.evict_wrote_back         = r_wrote_back;
    assign bus.victim_set               = r_set;
    assign bus.victim_way               = r_way;
    assign bus.clear_selected_dirty_bit = w_clear;
    assign bus.data_rd_en               = w_data_rd_en;
    assign bus.data_word                = r_word;
    assign bus.mem_req                  = w_mem_req;
    assign bus.mem_addr                 = w_tag_part | w_set_part | w_word_part;
    assign bus.mem_wdata                = r_wdata;

`ifdef WB_STATS_EN
    logic [15:0] r_wb_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_count <= 16'h0000;
        end else if ((r_state == c_ST_CLEAR) && (r_wb_count != 16'hFFFF)) begin
            r_wb_count <= r_wb_count + 16'h0001;
        end
    end

    assign bus.wb_count = r_wb_count;
`else
    assign bus.wb_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_controller.sv
`default_nettype none
//==============================================================================
// Module   : tb_writeback_controller
// Brief    : Randomised and directed bench for writeback_controller against a
//            cycle-count and write-list reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_writeback_controller;
    localparam int NUM_SETS = 8;
    localparam int ASSOC    = 2;
    localparam int LW       = 4;
    localparam int XLEN     = 32;
    localparam int AW       = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    writeback_controller_if #(.NUM_SETS(NUM_SETS), .ASSOC(ASSOC), .LINE_WORDS(LW),
                              .XLEN(XLEN), .ADDR_WIDTH(AW)) bus ();

    writeback_controller #(.NUM_SETS(NUM_SETS), .ASSOC(ASSOC), .LINE_WORDS(LW),
                           .XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Environment model: dirty-bit array, line contents, memory ack timing
    logic        dirty [NUM_SETS][ASSOC];
    logic [31:0] line_data [LW];
    int          ack_delay [LW];
    int          ack_mode;      // outside WRITE: 0 low, 1 random, 2 high
    int          exp_wb;

    // Observations gathered by the monitor
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          words_acked, wait_cnt, clears, stab_err, req_cycles;
    bit          hold_valid;
    logic [31:0] hold_addr, hold_data;
    logic [2:0]  clr_set;
    logic        clr_way;

    assign bus.selected_dirty_bit = dirty[bus.victim_set][bus.victim_way];
    // The array presents the addressed word while data_rd_en is high, junk otherwise
    assign bus.data_rdata = bus.data_rd_en ? line_data[bus.data_word] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        #1;
        if (bus.mem_req) begin
            bus.mem_ack = (wait_cnt >= ack_delay[words_acked % LW]);
        end else begin
            case (ack_mode)
                1:       bus.mem_ack = 1'($urandom_range(0, 1));
                2:       bus.mem_ack = 1'b1;
                default: bus.mem_ack = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (bus.mem_req) begin
            req_cycles++;
            if (hold_valid && (bus.mem_addr !== hold_addr || bus.mem_wdata !== hold_data)) begin
                stab_err++;
            end
            if (bus.mem_ack) begin
                wr_addr_q.push_back(bus.mem_addr);
                wr_data_q.push_back(bus.mem_wdata);
                words_acked++;
                wait_cnt   = 0;
                hold_valid = 1'b0;
            end else begin
                hold_valid = 1'b1;
                hold_addr  = bus.mem_addr;
                hold_data  = bus.mem_wdata;
                wait_cnt++;
            end
        end else begin
            hold_valid = 1'b0;
        end
        if (bus.clear_selected_dirty_bit) begin
            clears++;
            clr_set = bus.victim_set;
            clr_way = bus.victim_way;
            dirty[bus.victim_set][bus.victim_way] = 1'b0;
        end
    end

    task automatic clear_obs();
        wr_addr_q.delete();
        wr_data_q.delete();
        words_acked = 0;
        wait_cnt    = 0;
        clears      = 0;
        stab_err    = 0;
        req_cycles  = 0;
        hold_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            if (bus.evict_ready === 1'b1) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL %s ready_timeout: evict_ready stayed %b, required 1", name, bus.evict_ready);
    endtask

    // One eviction from request to the cycle after evict_done; called at a negedge
    task automatic run_evict(input logic [24:0] tag, input logic [2:0] set, input logic way,
                             input bit is_dirty, input string name);
        int          c0, rel, exp_rel, n, exp_cnt;
        bit          got;
        logic [31:0] exp_addr;
        dirty[set][way] = is_dirty;
        clear_obs();
        wait_idle(name);
        bus.evict_valid = 1'b1;
        bus.evict_set   = set;
        bus.evict_way   = way;
        bus.evict_tag   = tag;
        c0 = cyc;
        @(negedge clk);
        bus.evict_valid = 1'b0;
        bus.evict_set   = 3'($urandom);
        bus.evict_way   = 1'($urandom);
        bus.evict_tag   = 25'($urandom);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.evict_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rel = cyc - c0;
        exp_rel = 2;
        if (is_dirty) begin
            exp_rel = 2 * LW + 3;
            for (int w = 0; w < LW; w++) exp_rel += ack_delay[w];
            exp_wb++;
        end
`ifdef WB_STATS_EN
        exp_cnt = (exp_wb > 65535) ? 65535 : exp_wb;
`else
        exp_cnt = 0;
`endif
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s done_timeout: no evict_done within 200 cycles", name);
        end
        total++;
        if (rel !== exp_rel) begin
            bad++;
            $display("FAIL %s done_cycle: got %0d required %0d", name, rel, exp_rel);
        end
        total++;
        if (bus.evict_wrote_back !== is_dirty) begin
            bad++;
            $display("FAIL %s wrote_back: got %b required %b", name, bus.evict_wrote_back, is_dirty);
        end
        total++;
        if ({bus.victim_set, bus.victim_way} !== {set, way}) begin
            bad++;
            $display("FAIL %s victim: got %h/%h required %h/%h", name, bus.victim_set, bus.victim_way, set, way);
        end
        total++;
        if (bus.wb_count !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL %s wb_count: got %0d required %0d", name, bus.wb_count, exp_cnt);
        end
        n = is_dirty ? LW : 0;
        total++;
        if (wr_addr_q.size() != n) begin
            bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), n);
        end
        for (int w = 0; w < n && w < wr_addr_q.size(); w++) begin
            exp_addr = {tag, set, 2'(w), 2'b00};
            total++;
            if (wr_addr_q[w] !== exp_addr || wr_data_q[w] !== line_data[w]) begin
                bad++;
                $display("FAIL %s write%0d: got %h:%h required %h:%h", name, w,
                         wr_addr_q[w], wr_data_q[w], exp_addr, line_data[w]);
            end
        end
        total++;
        if (clears != int'(is_dirty)) begin
            bad++;
            $display("FAIL %s clear_pulses: got %0d required %0d", name, clears, is_dirty);
        end
        if (is_dirty) begin
            total++;
            if ({clr_set, clr_way} !== {set, way} || dirty[set][way] !== 1'b0) begin
                bad++;
                $display("FAIL %s clear_target: got %h/%h bit=%b required %h/%h bit=0", name,
                         clr_set, clr_way, dirty[set][way], set, way);
            end
        end
        total++;
        if (stab_err != 0) begin
            bad++;
            $display("FAIL %s hold_stable: got %0d changes required 0", name, stab_err);
        end
        @(negedge clk);
        total++;
        if ({bus.evict_ready, bus.evict_done} !== 2'b10) begin
            bad++;
            $display("FAIL %s after_done: ready/done got %b required 10", name, {bus.evict_ready, bus.evict_done});
        end
    endtask

    task automatic set_line(input logic [31:0] base, input bit rnd);
        for (int w = 0; w < LW; w++) line_data[w] = rnd ? $urandom : base + 32'(w);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({bus.evict_ready, bus.evict_done, bus.evict_wrote_back, bus.clear_selected_dirty_bit,
             bus.data_rd_en, bus.mem_req} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_strobes: got %b required 100000", {bus.evict_ready, bus.evict_done,
                     bus.evict_wrote_back, bus.clear_selected_dirty_bit, bus.data_rd_en, bus.mem_req});
        end
        total++;
        if ({bus.victim_set, bus.victim_way, bus.data_word, bus.mem_addr, bus.mem_wdata, bus.wb_count} !== '0) begin
            bad++;
            $display("FAIL reset_regs: set=%h way=%h word=%h addr=%h wdata=%h cnt=%h required all 0",
                     bus.victim_set, bus.victim_way, bus.data_word, bus.mem_addr, bus.mem_wdata, bus.wb_count);
        end
        rst_n = 1'b1;
        exp_wb = 0;
        @(negedge clk);
        total++;
        if ({bus.evict_ready, bus.mem_req} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: ready/req got %b required 10", {bus.evict_ready, bus.mem_req});
        end
    endtask

    task automatic test_clean();
        ack_mode = 1;
        set_line(32'h0, 1'b1);
        run_evict(25'h0_0012, 3'd3, 1'b1, 1'b0, "clean");
        total++;
        if (req_cycles != 0) begin
            bad++;
            $display("FAIL clean mem_req_cycles: got %0d required 0", req_cycles);
        end
    endtask

    task automatic test_dirty();
        ack_mode = 2;
        for (int w = 0; w < LW; w++) ack_delay[w] = 0;
        set_line(32'hA0, 1'b0);
        run_evict(25'h0_0012, 3'd3, 1'b0, 1'b1, "dirty");
    endtask

    task automatic test_delayed_ack();
        ack_mode = 0;
        ack_delay = '{0, 0, 3, 0};
        set_line(32'hB0, 1'b0);
        run_evict(25'h1_5A5A, 3'd6, 1'b1, 1'b1, "delayed");
        total++;
        if (req_cycles != LW + 3) begin
            bad++;
            $display("FAIL delayed mem_req_cycles: got %0d required %0d", req_cycles, LW + 3);
        end
        ack_delay = '{0, 0, 0, 0};
    endtask

    task automatic test_back_to_back();
        int c0, acc, d1, d2, nd;
        ack_mode = 0;
        set_line(32'hC0, 1'b0);
        dirty[5][0] = 1'b1;
        clear_obs();
        wait_idle("back_to_back");
        bus.evict_valid = 1'b1;
        bus.evict_set   = 3'd5;
        bus.evict_way   = 1'b0;
        bus.evict_tag   = 25'h0_0777;
        c0 = cyc;
        acc = 1;
        nd = 0;
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 100 && nd < 2; i++) begin
            @(negedge clk);
            if (bus.evict_ready === 1'b1) acc++;
            if (bus.evict_done === 1'b1) begin
                if (nd == 0) d1 = cyc - c0;
                else d2 = cyc - c0;
                nd++;
            end
        end
        bus.evict_valid = 1'b0;
        exp_wb++;
        total++;
        if (d1 != 2 * LW + 3 || d2 != 2 * LW + 6) begin
            bad++;
            $display("FAIL back_to_back done_cycles: got %0d,%0d required %0d,%0d", d1, d2, 2 * LW + 3, 2 * LW + 6);
        end
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL back_to_back accepts: got %0d required 2", acc);
        end
        total++;
        if (wr_addr_q.size() != LW || clears != 1) begin
            bad++;
            $display("FAIL back_to_back writes/clears: got %0d/%0d required %0d/1", wr_addr_q.size(), clears, LW);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [24:0] tag;
        logic [2:0]  set;
        logic        way;
        bit          d;
        ack_mode = 1;
        for (int k = 0; k < 24; k++) begin
            tag = 25'($urandom);
            set = 3'($urandom);
            way = 1'($urandom);
            d   = 1'($urandom);
            set_line(32'h0, 1'b1);
            for (int w = 0; w < LW; w++) ack_delay[w] = $urandom_range(0, 3);
            run_evict(tag, set, way, d, "random");
        end
        ack_delay = '{0, 0, 0, 0};
    endtask

    task automatic test_reset_mid();
        bit hit;
        ack_mode = 0;
        ack_delay = '{0, 6, 0, 0};
        set_line(32'hD0, 1'b0);
        dirty[2][1] = 1'b1;
        clear_obs();
        wait_idle("reset_mid");
        bus.evict_valid = 1'b1;
        bus.evict_set   = 3'd2;
        bus.evict_way   = 1'b1;
        bus.evict_tag   = 25'h0_0ABC;
        @(negedge clk);
        bus.evict_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_req === 1'b1 && bus.mem_addr[3:2] == 2'd1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL reset_mid reach_word1: mem_req for word 1 not seen");
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.mem_req, bus.evict_ready, bus.clear_selected_dirty_bit, bus.evict_done} !== 4'b0100) begin
            bad++;
            $display("FAIL reset_mid outputs: req/ready/clear/done got %b required 0100",
                     {bus.mem_req, bus.evict_ready, bus.clear_selected_dirty_bit, bus.evict_done});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_wb = 0;
        repeat (2) @(negedge clk);
        total++;
        if (clears != 0 || dirty[2][1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid dirty_kept: clears=%0d bit=%b required 0/1", clears, dirty[2][1]);
        end
        total++;
        if ({bus.evict_ready, bus.evict_done, bus.wb_count} !== {2'b10, 16'h0}) begin
            bad++;
            $display("FAIL reset_mid idle: ready/done got %b cnt=%0d required 10 cnt=0",
                     {bus.evict_ready, bus.evict_done}, bus.wb_count);
        end
        ack_delay = '{0, 0, 0, 0};
    endtask

    task automatic test_stats();
        ack_mode = 1;
        set_line(32'h0, 1'b1);
        run_evict(25'h0_0100, 3'd0, 1'b0, 1'b1, "stats_d0");
        run_evict(25'h0_0101, 3'd1, 1'b1, 1'b0, "stats_c0");
        run_evict(25'h0_0102, 3'd4, 1'b0, 1'b1, "stats_d1");
        run_evict(25'h0_0103, 3'd7, 1'b1, 1'b0, "stats_c1");
        run_evict(25'h0_0104, 3'd2, 1'b1, 1'b1, "stats_d2");
    endtask

    initial begin
        for (int s = 0; s < NUM_SETS; s++)
            for (int a = 0; a < ASSOC; a++) dirty[s][a] = 1'b0;
        ack_delay       = '{0, 0, 0, 0};
        ack_mode        = 0;
        exp_wb          = 0;
        bus.evict_valid = 1'b0;
        bus.evict_set   = '0;
        bus.evict_way   = '0;
        bus.evict_tag   = '0;
        bus.mem_ack     = 1'b0;
        clear_obs();
        test_reset();
        test_clean();
        test_dirty();
        test_delayed_ack();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
